// File: rtl/pq_request_scheduler.sv
// Push buffer plus issue scheduler in front of the register-tree priority queue.
// Latency: push -> o_q_wrt 2 cycles from idle/empty; pop -> m_pop_valid 1 cycle; ops spaced SETTLE_CYCLES+2.
// Backpressure: s_push_ready while the push buffer has room; s_pop_ready only in IDLE with a free slot and non-empty queue.

module pq_sched_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign rd_dat = mem[rd_ptr];

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the count says empty.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

module pq_request_scheduler #(
  parameter int DATA_WIDTH    = 16,
  parameter int QUEUE_SIZE    = 128,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  s_push_valid,
  output logic                  s_push_ready,
  input  logic [DATA_WIDTH-1:0] s_push_data,
  input  logic                  s_pop_valid,
  output logic                  s_pop_ready,
  output logic                  m_pop_valid,
  input  logic                  m_pop_ready,
  output logic [DATA_WIDTH-1:0] m_pop_data,
  output logic                  o_q_wrt,
  output logic                  o_q_read,
  output logic [DATA_WIDTH-1:0] o_q_data,
  input  logic                  i_q_full,
  input  logic                  i_q_empty,
  input  logic [DATA_WIDTH-1:0] i_q_data,
  output logic                  o_zero_drop,
  output logic                  o_busy
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // Reject configurations the pointer arithmetic and settle counter cannot handle.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SETTLE_CYCLES < 1 || QUEUE_SIZE < 1) begin : g_bad_params
    $error("pq_request_scheduler: invalid parameter set");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [SW-1:0]         settle_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push_fire;
  logic                  push_zero;
  logic                  slot_free;
  logic                  replace_ok;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  issue_wrt;
  logic                  issue_rd;
  logic                  deq;
  logic                  pop_take;

  assign s_push_ready = !fifo_full;
  assign push_fire    = s_push_valid && s_push_ready;
  assign push_zero    = (s_push_data == '0);
  assign slot_free    = !m_pop_valid || m_pop_ready;

  // Zero marks an empty queue slot, so zero pushes are swallowed here.
  pq_sched_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_push_fifo (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .wr_en  (push_fire && !push_zero),
    .wr_dat (s_push_data),
    .rd_en  (deq),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign replace_ok = s_pop_valid && slot_free && !fifo_empty && !i_q_empty;
  assign push_ok    = !fifo_empty && !i_q_full;
  assign pop_ok     = s_pop_valid && slot_free && !i_q_empty;

  assign s_pop_ready = pop_take;
  assign o_busy      = (state != IDLE) || !fifo_empty;

  // Issue decision (replace > push > pop) and the IDLE/ISSUE/SETTLE sequencing.
  always_comb begin
    state_nxt = state;
    issue_wrt = 1'b0;
    issue_rd  = 1'b0;
    deq       = 1'b0;
    pop_take  = 1'b0;
    case (state)
      IDLE: begin
        if (replace_ok) begin
          issue_wrt = 1'b1;
          issue_rd  = 1'b1;
          deq       = 1'b1;
          pop_take  = 1'b1;
          state_nxt = ISSUE;
        end else if (push_ok) begin
          issue_wrt = 1'b1;
          deq       = 1'b1;
          state_nxt = ISSUE;
        end else if (pop_ok) begin
          issue_rd  = 1'b1;
          pop_take  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Settle counter: loaded while leaving ISSUE, counts down through SETTLE.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      settle_cnt <= '0;
    end else if (state == ISSUE) begin
      settle_cnt <= SW'(SETTLE_CYCLES - 1);
    end else if (state == SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Queue strobes last exactly the ISSUE cycle; write data holds the dequeued head.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      o_q_wrt  <= 1'b0;
      o_q_read <= 1'b0;
      o_q_data <= '0;
    end else begin
      o_q_wrt  <= issue_wrt;
      o_q_read <= issue_rd;
      if (deq) o_q_data <= fifo_head;
    end
  end

  // Output slot: reload on an accepted pop, otherwise drain on consumer handshake.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_pop_valid <= 1'b0;
      m_pop_data  <= '0;
    end else if (pop_take) begin
      m_pop_valid <= 1'b1;
      m_pop_data  <= i_q_data;
    end else if (m_pop_valid && m_pop_ready) begin
      m_pop_valid <= 1'b0;
    end
  end

  // One-cycle notice that an accepted zero push was discarded.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) o_zero_drop <= 1'b0;
    else       o_zero_drop <= push_fire && push_zero;
  end
endmodule

// File: tb/tb_pq_request_scheduler.sv
// Directed bench for pq_request_scheduler with hand-derived expected values.
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns after it.
// Every wait on the design is bounded and counted.

module tb_pq_request_scheduler;
  logic        CLK = 1'b0;
  logic        RSTn;
  logic        s_push_valid;
  logic        s_push_ready;
  logic [15:0] s_push_data;
  logic        s_pop_valid;
  logic        s_pop_ready;
  logic        m_pop_valid;
  logic        m_pop_ready;
  logic [15:0] m_pop_data;
  logic        o_q_wrt;
  logic        o_q_read;
  logic [15:0] o_q_data;
  logic        i_q_full;
  logic        i_q_empty;
  logic [15:0] i_q_data;
  logic        o_zero_drop;
  logic        o_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  pq_request_scheduler #(
    .DATA_WIDTH(16), .QUEUE_SIZE(128), .FIFO_DEPTH(4), .SETTLE_CYCLES(8)
  ) dut (
    .CLK(CLK), .RSTn(RSTn),
    .s_push_valid(s_push_valid), .s_push_ready(s_push_ready), .s_push_data(s_push_data),
    .s_pop_valid(s_pop_valid), .s_pop_ready(s_pop_ready),
    .m_pop_valid(m_pop_valid), .m_pop_ready(m_pop_ready), .m_pop_data(m_pop_data),
    .o_q_wrt(o_q_wrt), .o_q_read(o_q_read), .o_q_data(o_q_data),
    .i_q_full(i_q_full), .i_q_empty(i_q_empty), .i_q_data(i_q_data),
    .o_zero_drop(o_zero_drop), .o_busy(o_busy)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (o_busy && n < bound) begin
      tick();
      n++;
    end
    vectors++;
    if (o_busy !== 1'b0) begin
      $display("FAIL wait_idle: o_busy=%b after %0d cycles, want 0", o_busy, n);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({s_push_ready, s_pop_ready, m_pop_valid, o_q_wrt, o_q_read, o_zero_drop, o_busy} !== 7'b1000000) begin
      $display("FAIL reset_flags: got %b want 1000000",
               {s_push_ready, s_pop_ready, m_pop_valid, o_q_wrt, o_q_read, o_zero_drop, o_busy});
      miscompares++;
    end
    vectors++;
    if (m_pop_data !== 16'h0 || o_q_data !== 16'h0) begin
      $display("FAIL reset_data: m_pop_data=%h o_q_data=%h want 0000 0000", m_pop_data, o_q_data);
      miscompares++;
    end
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_single_push_pop();
    int n;
    s_push_valid = 1'b1;
    s_push_data  = 16'h0005;
    #1;
    vectors++;
    if (s_push_ready !== 1'b1) begin
      $display("FAIL spp_push_ready: got %b want 1", s_push_ready);
      miscompares++;
    end
    tick();                                   // cycle t+1
    s_push_valid = 1'b0;
    vectors++;
    if (o_q_wrt !== 1'b0 || o_busy !== 1'b1) begin
      $display("FAIL spp_t1: o_q_wrt=%b o_busy=%b want 0 1", o_q_wrt, o_busy);
      miscompares++;
    end
    tick();                                   // cycle t+2 (ISSUE)
    vectors++;
    if (o_q_wrt !== 1'b1 || o_q_read !== 1'b0 || o_q_data !== 16'h0005) begin
      $display("FAIL spp_write: wrt=%b read=%b data=%h want 1 0 0005", o_q_wrt, o_q_read, o_q_data);
      miscompares++;
    end
    i_q_empty   = 1'b0;
    i_q_data    = 16'h0005;
    s_pop_valid = 1'b1;
    m_pop_ready = 1'b0;
    n = 0;
    #1;
    while (!s_pop_ready && n < 30) begin
      tick();
      #1;
      n++;
    end
    vectors++;
    if (n !== 9) begin
      $display("FAIL spp_pop_ready_delay: got %0d cycles want 9", n);
      miscompares++;
    end
    tick();
    s_pop_valid = 1'b0;
    vectors++;
    if (m_pop_valid !== 1'b1 || m_pop_data !== 16'h0005 || o_q_read !== 1'b1 || o_q_wrt !== 1'b0) begin
      $display("FAIL spp_pop: valid=%b data=%h read=%b wrt=%b want 1 0005 1 0",
               m_pop_valid, m_pop_data, o_q_read, o_q_wrt);
      miscompares++;
    end
    i_q_empty = 1'b1;
    i_q_data  = 16'h0000;
    tick();
    vectors++;
    if (o_q_read !== 1'b0 || m_pop_valid !== 1'b1) begin
      $display("FAIL spp_hold: read=%b m_pop_valid=%b want 0 1", o_q_read, m_pop_valid);
      miscompares++;
    end
    m_pop_ready = 1'b1;
    tick();
    m_pop_ready = 1'b0;
    vectors++;
    if (m_pop_valid !== 1'b0) begin
      $display("FAIL spp_drain: m_pop_valid=%b want 0", m_pop_valid);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    int          pulse_cyc [4];
    logic [15:0] pulse_dat [4];
    int          np = 0;
    int          nrd = 0;
    vals = '{16'h0003, 16'h0009, 16'h0001, 16'h0007};
    wait_idle(40);
    m_pop_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 4) begin
        s_push_valid = 1'b1;
        s_push_data  = vals[c];
      end else begin
        s_push_valid = 1'b0;
      end
      #1;
      if (c == 4) begin
        vectors++;
        if (s_push_ready !== 1'b1) begin
          $display("FAIL b2b_push_ready: got %b want 1 (one entry drained)", s_push_ready);
          miscompares++;
        end
      end
      if (o_q_wrt === 1'b1) begin
        if (np < 4) begin
          pulse_cyc[np] = c;
          pulse_dat[np] = o_q_data;
        end
        np++;
      end
      if (o_q_read === 1'b1) nrd++;
      tick();
    end
    vectors++;
    if (np !== 4 || nrd !== 0) begin
      $display("FAIL b2b_count: writes=%0d reads=%0d want 4 0", np, nrd);
      miscompares++;
    end
    for (int k = 0; k < 4 && k < np; k++) begin
      vectors++;
      if (pulse_cyc[k] !== 2 + 10 * k || pulse_dat[k] !== vals[k]) begin
        $display("FAIL b2b_pulse%0d: cycle=%0d data=%h want %0d %h",
                 k, pulse_cyc[k], pulse_dat[k], 2 + 10 * k, vals[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_zero_push();
    int nz = 0;
    int nw = 0;
    int nb = 0;
    wait_idle(40);
    s_push_valid = 1'b1;
    s_push_data  = 16'h0000;
    #1;
    vectors++;
    if (s_push_ready !== 1'b1) begin
      $display("FAIL zero_ready: got %b want 1", s_push_ready);
      miscompares++;
    end
    tick();
    s_push_valid = 1'b0;
    vectors++;
    if (o_zero_drop !== 1'b1 || o_busy !== 1'b0) begin
      $display("FAIL zero_pulse: o_zero_drop=%b o_busy=%b want 1 0", o_zero_drop, o_busy);
      miscompares++;
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_zero_drop === 1'b1) nz++;
      if (o_q_wrt === 1'b1) nw++;
      if (o_busy === 1'b1) nb++;
    end
    vectors++;
    if (nz !== 0 || nw !== 0 || nb !== 0) begin
      $display("FAIL zero_after: extra drops=%0d writes=%0d busy=%0d want 0 0 0", nz, nw, nb);
      miscompares++;
    end
  endtask

  task automatic test_replace();
    wait_idle(40);
    i_q_full    = 1'b0;
    i_q_empty   = 1'b0;
    i_q_data    = 16'h0020;
    m_pop_ready = 1'b0;
    s_push_valid = 1'b1;
    s_push_data  = 16'h0011;
    tick();
    s_push_valid = 1'b0;
    s_pop_valid  = 1'b1;
    #1;
    vectors++;
    if (s_pop_ready !== 1'b1) begin
      $display("FAIL rep_pop_ready: got %b want 1", s_pop_ready);
      miscompares++;
    end
    tick();
    s_pop_valid = 1'b0;
    vectors++;
    if (o_q_wrt !== 1'b1 || o_q_read !== 1'b1 || o_q_data !== 16'h0011) begin
      $display("FAIL rep_pulse: wrt=%b read=%b data=%h want 1 1 0011", o_q_wrt, o_q_read, o_q_data);
      miscompares++;
    end
    vectors++;
    if (m_pop_valid !== 1'b1 || m_pop_data !== 16'h0020) begin
      $display("FAIL rep_result: valid=%b data=%h want 1 0020", m_pop_valid, m_pop_data);
      miscompares++;
    end
    m_pop_ready = 1'b1;
    tick();
    m_pop_ready = 1'b0;
  endtask

  task automatic test_full_replace();
    int nw = 0;
    wait_idle(40);
    i_q_full    = 1'b1;
    i_q_empty   = 1'b0;
    i_q_data    = 16'h0020;
    m_pop_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_push_valid = 1'b1;
      s_push_data  = 16'h0011 + 16'(k);
      #1;
      if (o_q_wrt === 1'b1) nw++;
      tick();
    end
    s_push_valid = 1'b0;
    #1;
    vectors++;
    if (s_push_ready !== 1'b0) begin
      $display("FAIL full_push_ready: got %b want 0 (buffer full)", s_push_ready);
      miscompares++;
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_q_wrt === 1'b1) nw++;
    end
    vectors++;
    if (nw !== 0) begin
      $display("FAIL full_no_write: writes=%0d want 0", nw);
      miscompares++;
    end
    s_pop_valid = 1'b1;
    #1;
    vectors++;
    if (s_pop_ready !== 1'b1) begin
      $display("FAIL full_pop_ready: got %b want 1", s_pop_ready);
      miscompares++;
    end
    tick();
    s_pop_valid = 1'b0;
    vectors++;
    if (o_q_wrt !== 1'b1 || o_q_read !== 1'b1 || o_q_data !== 16'h0011 || m_pop_data !== 16'h0020) begin
      $display("FAIL full_replace: wrt=%b read=%b qdata=%h pdata=%h want 1 1 0011 0020",
               o_q_wrt, o_q_read, o_q_data, m_pop_data);
      miscompares++;
    end
    vectors++;
    if (s_push_ready !== 1'b1) begin
      $display("FAIL full_reopen: s_push_ready=%b want 1", s_push_ready);
      miscompares++;
    end
    i_q_full = 1'b0;
    wait_idle(100);
    m_pop_ready = 1'b0;
  endtask

  task automatic test_pop_empty();
    int bad = 0;
    wait_idle(40);
    i_q_empty   = 1'b1;
    i_q_full    = 1'b0;
    s_pop_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (s_pop_ready !== 1'b0 || o_q_wrt !== 1'b0 || o_q_read !== 1'b0) bad++;
      tick();
    end
    s_pop_valid = 1'b0;
    vectors++;
    if (bad !== 0) begin
      $display("FAIL pop_empty: %0d cycles with ready or pulse, want 0", bad);
      miscompares++;
    end
  endtask

  task automatic test_reset_settle();
    int nw = 0;
    wait_idle(40);
    i_q_empty   = 1'b0;
    i_q_full    = 1'b1;
    i_q_data    = 16'h0040;
    m_pop_ready = 1'b0;
    s_push_valid = 1'b1;
    s_push_data  = 16'h0021;
    s_pop_valid  = 1'b1;
    #1;
    vectors++;
    if (s_pop_ready !== 1'b1) begin
      $display("FAIL rs_pop_ready: got %b want 1", s_pop_ready);
      miscompares++;
    end
    tick();
    s_pop_valid  = 1'b0;
    s_push_data  = 16'h0022;
    tick();
    s_push_valid = 1'b0;
    tick();
    vectors++;
    if (m_pop_valid !== 1'b1 || o_busy !== 1'b1 || m_pop_data !== 16'h0040) begin
      $display("FAIL rs_pre: m_pop_valid=%b o_busy=%b data=%h want 1 1 0040", m_pop_valid, o_busy, m_pop_data);
      miscompares++;
    end
    RSTn = 1'b0;
    #1;
    vectors++;
    if ({s_push_ready, s_pop_ready, m_pop_valid, o_q_wrt, o_q_read, o_zero_drop, o_busy} !== 7'b1000000 ||
        m_pop_data !== 16'h0 || o_q_data !== 16'h0) begin
      $display("FAIL rs_reset: flags=%b pdata=%h qdata=%h want 1000000 0000 0000",
               {s_push_ready, s_pop_ready, m_pop_valid, o_q_wrt, o_q_read, o_zero_drop, o_busy},
               m_pop_data, o_q_data);
      miscompares++;
    end
    i_q_full  = 1'b0;
    i_q_empty = 1'b1;
    #2;
    RSTn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (o_q_wrt === 1'b1) nw++;
    end
    vectors++;
    if (nw !== 0 || o_busy !== 1'b0) begin
      $display("FAIL rs_after: writes=%0d o_busy=%b want 0 0", nw, o_busy);
      miscompares++;
    end
  endtask

  initial begin
    RSTn         = 1'b0;
    s_push_valid = 1'b0;
    s_push_data  = 16'h0;
    s_pop_valid  = 1'b0;
    m_pop_ready  = 1'b0;
    i_q_full     = 1'b0;
    i_q_empty    = 1'b1;
    i_q_data     = 16'h0;
    test_reset();
    test_single_push_pop();
    test_back_to_back();
    test_zero_push();
    test_replace();
    test_full_replace();
    test_pop_empty();
    test_reset_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
